// File: rtl/heartbeat_rx.sv
// Heartbeat receiver: recovers Manchester half-bit phase and byte alignment
// from the transmitter's free-running counter stream. It checks that each byte
// is the previous byte + 1 and presents the accepted bytes while locked.
// Optional feature macro: HEARTBEAT_RX_ERRCNT_EN adds a saturating 8-bit
// err_count output.
module heartbeat_rx #(
  parameter int unsigned PHASE_GOOD = 8,
  parameter int unsigned CONFIRM    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       locked,
  output logic       err
`ifdef HEARTBEAT_RX_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  typedef enum logic [1:0] {StPhase, StHunt, StVerify, StLocked} state_e;

  localparam logic [3:0] PhaseGoodM1 = 4'(PHASE_GOOD - 1);
  localparam logic [2:0] ConfirmM1   = 3'(CONFIRM - 1);

  state_e      state_q;
  logic        prev_q;      // previous sample, i.e. first half of the current pair
  logic        ph_q;        // high on the second half of a pair
  logic [3:0]  good_cnt_q;
  logic [15:0] sr_q;
  logic [4:0]  bit_cnt_q;   // HUNT: bits held (saturates at 16); else bit within byte
  logic [2:0]  conf_cnt_q;
  logic [7:0]  last_q;

  logic        pair_valid;
  logic [15:0] sr_shift;
  logic [7:0]  byte_new;
  logic [7:0]  hunt_hi_inc;
  logic [7:0]  last_inc;

  // Pair decode and byte arithmetic, all 8-bit modulo.
  always_comb begin
    pair_valid  = prev_q ^ din;
    sr_shift    = {sr_q[14:0], prev_q};
    byte_new    = sr_shift[7:0];
    hunt_hi_inc = sr_shift[15:8] + 8'd1;
    last_inc    = last_q + 8'd1;
  end

  // Acquisition / tracking FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StPhase;
      prev_q     <= 1'b0;
      ph_q       <= 1'b0;
      good_cnt_q <= '0;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      conf_cnt_q <= '0;
      last_q     <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      prev_q     <= din;
      ph_q       <= ~ph_q;
      data_valid <= 1'b0;
      err        <= 1'b0;
      if (ph_q) begin
        unique case (state_q)
          StPhase: begin
            if (pair_valid) begin
              if (good_cnt_q == PhaseGoodM1) begin
                state_q    <= StHunt;
                good_cnt_q <= '0;
                sr_q       <= '0;
                bit_cnt_q  <= '0;
              end else begin
                good_cnt_q <= good_cnt_q + 4'd1;
              end
            end else begin
              // Slip: keep ph high so the next pair starts one sample later.
              good_cnt_q <= '0;
              ph_q       <= 1'b1;
            end
          end
          StHunt: begin
            if (!pair_valid) begin
              err        <= 1'b1;
              state_q    <= StPhase;
              good_cnt_q <= '0;
            end else begin
              sr_q <= sr_shift;
              if (bit_cnt_q != 5'd16) bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q >= 5'd15 && hunt_hi_inc == sr_shift[7:0]) begin
                last_q     <= sr_shift[7:0];
                bit_cnt_q  <= '0;
                conf_cnt_q <= '0;
                state_q    <= StVerify;
              end
            end
          end
          StVerify: begin
            if (!pair_valid) begin
              err        <= 1'b1;
              state_q    <= StPhase;
              good_cnt_q <= '0;
            end else begin
              sr_q <= sr_shift;
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= '0;
                if (byte_new == last_inc) begin
                  last_q     <= byte_new;
                  conf_cnt_q <= conf_cnt_q + 3'd1;
                  if (conf_cnt_q == ConfirmM1) begin
                    state_q <= StLocked;
                    locked  <= 1'b1;
                  end
                end else begin
                  err     <= 1'b1;
                  sr_q    <= '0;
                  state_q <= StHunt;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          StLocked: begin
            if (!pair_valid) begin
              err        <= 1'b1;
              locked     <= 1'b0;
              state_q    <= StPhase;
              good_cnt_q <= '0;
            end else begin
              sr_q <= sr_shift;
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= '0;
                if (byte_new == last_inc) begin
                  last_q     <= byte_new;
                  data       <= byte_new;
                  data_valid <= 1'b1;
                end else begin
                  // Mismatched byte is dropped, not presented.
                  err     <= 1'b1;
                  locked  <= 1'b0;
                  sr_q    <= '0;
                  state_q <= StHunt;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          default: state_q <= StPhase;
        endcase
      end
    end
  end

`ifdef HEARTBEAT_RX_ERRCNT_EN
  // Saturating count of err pulses; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_heartbeat_rx.sv
// Directed self-checking bench for heartbeat_rx with an ideal transmitter model.
module tb_heartbeat_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       locked;
  logic       err;
`ifdef HEARTBEAT_RX_ERRCNT_EN
  logic [7:0] err_count;
`endif

  heartbeat_rx #(
    .PHASE_GOOD(8),
    .CONFIRM   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .data      (data),
    .data_valid(data_valid),
    .locked    (locked),
    .err       (err)
`ifdef HEARTBEAT_RX_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Transmitter model state
  logic [7:0] tx_byte;
  logic [3:0] tx_pos;
  int         filler;
  bit         corrupt_en;
  logic [7:0] corrupt_byte;
  bit         skip_en;
  int         tk;

  // Observed outputs (after the edge that consumed the last driven sample)
  logic [7:0] obs_data;
  logic       obs_dv, obs_locked, obs_err, prev_locked;

  int         dv_tick[$];
  logic [7:0] dv_data[$];
  int         err_tick[$];
  int         err_lock[$];
  int         rise_tick[$];
  int         fall_tick[$];

  task automatic drive_next();
    logic s;
    if (filler > 0) begin
      din = 1'b0;
      filler--;
    end else begin
      s = tx_byte[3'd7 - tx_pos[3:1]] ^ tx_pos[0];
      if (corrupt_en && tx_byte == corrupt_byte && tx_pos == 4'd9) begin
        din = ~s;  // second half made equal to the first half
        corrupt_en = 1'b0;
      end else begin
        din = s;
      end
      if (tx_pos == 4'd15) begin
        tx_pos = 4'd0;
        if (skip_en && tx_byte == 8'h41) begin
          tx_byte = 8'h43;
          skip_en = 1'b0;
        end else begin
          tx_byte = tx_byte + 8'd1;
        end
      end else begin
        tx_pos = tx_pos + 4'd1;
      end
    end
  endtask

  task automatic observe();
    prev_locked = obs_locked;
    obs_data    = data;
    obs_dv      = data_valid;
    obs_locked  = locked;
    obs_err     = err;
    tk++;
  endtask

  task automatic tick();
    drive_next();
    @(negedge clk);
    observe();
  endtask

  task automatic tick_raw(input logic v);
    din = v;
    @(negedge clk);
    observe();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din = 1'b0;
    corrupt_en = 1'b0;
    skip_en = 1'b0;
    obs_locked = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Called at a negedge: releases reset and starts the stream on the next edge.
  task automatic start_stream(input logic [7:0] first, input int offset);
    tx_byte = first;
    tx_pos = 4'd0;
    filler = offset;
    tk = 0;
    obs_locked = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic wait_lock(output int t);
    t = 0;
    for (int i = 0; i < 120 && t == 0; i++) begin
      tick();
      if (obs_locked) t = tk;
    end
  endtask

  task automatic collect(input int n);
    dv_tick.delete(); dv_data.delete(); err_tick.delete(); err_lock.delete();
    rise_tick.delete(); fall_tick.delete();
    for (int i = 0; i < n; i++) begin
      tick();
      if (obs_dv) begin dv_tick.push_back(tk); dv_data.push_back(obs_data); end
      if (obs_err) begin err_tick.push_back(tk); err_lock.push_back(int'(obs_locked)); end
      if (obs_locked && !prev_locked) rise_tick.push_back(tk);
      if (!obs_locked && prev_locked) fall_tick.push_back(tk);
    end
  endtask

  task automatic test_reset();
    int dv_n, err_n, lk_n;
    do_reset();
    n_checks++;
    if ({data, data_valid, locked, err} !== 11'd0) begin
      $display("FAIL reset_outputs: got %03h, want 000", {data, data_valid, locked, err});
    end else n_pass++;
`ifdef HEARTBEAT_RX_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'h00) $display("FAIL reset_err_count: got %02h, want 00", err_count);
    else n_pass++;
`endif
    start_stream(8'h00, 0);
    dv_n = 0; err_n = 0; lk_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick_raw(1'b0);
      dv_n += int'(obs_dv); err_n += int'(obs_err); lk_n += int'(obs_locked);
    end
    n_checks++;
    if (dv_n !== 0 || err_n !== 0 || lk_n !== 0)
      $display("FAIL idle_stream: got dv=%0d err=%0d locked=%0d, want 0 0 0", dv_n, err_n, lk_n);
    else n_pass++;
  endtask

  // Checks the collected pulses against expected bytes, ticks and error ticks.
  task automatic test_aligned();
    int t;
    do_reset();
    start_stream(8'h00, 0);
    wait_lock(t);
    n_checks++;
    if (t !== 80) $display("FAIL aligned_lock_tick: got %0d, want 80", t); else n_pass++;
    collect(80);
    n_checks++;
    if (dv_data.size() !== 5 || err_tick.size() !== 0)
      $display("FAIL aligned_counts: got dv=%0d err=%0d, want 5 0", dv_data.size(), err_tick.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < dv_data.size(); i++) begin
      n_checks++;
      if (dv_data[i] !== 8'(5 + i) || dv_tick[i] !== 96 + 16 * i)
        $display("FAIL aligned_byte[%0d]: got %02h@%0d, want %02h@%0d", i, dv_data[i],
                 dv_tick[i], 8'(5 + i), 96 + 16 * i);
      else n_pass++;
    end
  endtask

  task automatic test_offset();
    int t;
    do_reset();
    start_stream(8'h00, 1);
    wait_lock(t);
    n_checks++;
    if (t !== 81) $display("FAIL offset_lock_tick: got %0d, want 81", t); else n_pass++;
    collect(80);
    n_checks++;
    if (dv_data.size() !== 5 || err_tick.size() !== 0)
      $display("FAIL offset_counts: got dv=%0d err=%0d, want 5 0", dv_data.size(), err_tick.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < dv_data.size(); i++) begin
      n_checks++;
      if (dv_data[i] !== 8'(5 + i) || dv_tick[i] !== 97 + 16 * i)
        $display("FAIL offset_byte[%0d]: got %02h@%0d, want %02h@%0d", i, dv_data[i],
                 dv_tick[i], 8'(5 + i), 97 + 16 * i);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int t;
    logic [7:0] exp_d [5];
    exp_d = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
    do_reset();
    start_stream(8'hF8, 0);
    wait_lock(t);
    n_checks++;
    if (t !== 80) $display("FAIL wrap_lock_tick: got %0d, want 80", t); else n_pass++;
    collect(80);
    n_checks++;
    if (dv_data.size() !== 5 || err_tick.size() !== 0)
      $display("FAIL wrap_counts: got dv=%0d err=%0d, want 5 0", dv_data.size(), err_tick.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < dv_data.size(); i++) begin
      n_checks++;
      if (dv_data[i] !== exp_d[i])
        $display("FAIL wrap_byte[%0d]: got %02h, want %02h", i, dv_data[i], exp_d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_violation();
    int t;
    logic [7:0] exp_d [4];
    int exp_t [4];
    exp_d = '{8'h05, 8'h06, 8'h07, 8'h0E};
    exp_t = '{96, 112, 128, 240};
    do_reset();
    corrupt_byte = 8'h08;
    corrupt_en = 1'b1;
    start_stream(8'h00, 0);
    wait_lock(t);
    n_checks++;
    if (t !== 80) $display("FAIL viol_lock_tick: got %0d, want 80", t); else n_pass++;
    collect(160);
    n_checks++;
    if (err_tick.size() !== 1 || (err_tick.size() > 0 && (err_tick[0] !== 138 || err_lock[0] !== 0)))
      $display("FAIL viol_err: got n=%0d first=%0d, want 1 at 138 with locked=0",
               err_tick.size(), err_tick.size() > 0 ? err_tick[0] : -1);
    else n_pass++;
    n_checks++;
    if (fall_tick.size() !== 1 || rise_tick.size() !== 1 ||
        (fall_tick.size() > 0 && fall_tick[0] !== 138) ||
        (rise_tick.size() > 0 && rise_tick[0] !== 224))
      $display("FAIL viol_relock: got falls=%0d rises=%0d, want drop at 138, relock at 224",
               fall_tick.size(), rise_tick.size());
    else n_pass++;
    n_checks++;
    if (dv_data.size() !== 4) $display("FAIL viol_dv_count: got %0d, want 4", dv_data.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < dv_data.size(); i++) begin
      n_checks++;
      if (dv_data[i] !== exp_d[i] || dv_tick[i] !== exp_t[i])
        $display("FAIL viol_byte[%0d]: got %02h@%0d, want %02h@%0d", i, dv_data[i], dv_tick[i],
                 exp_d[i], exp_t[i]);
      else n_pass++;
    end
  endtask

  task automatic test_seq_skip();
    int t;
    logic [7:0] exp_d [6];
    int exp_t [6];
    exp_d = '{8'h3D, 8'h3E, 8'h3F, 8'h40, 8'h41, 8'h48};
    exp_t = '{96, 112, 128, 144, 160, 256};
    do_reset();
    skip_en = 1'b1;
    start_stream(8'h38, 0);
    wait_lock(t);
    n_checks++;
    if (t !== 80) $display("FAIL skip_lock_tick: got %0d, want 80", t); else n_pass++;
    collect(176);
    n_checks++;
    if (err_tick.size() !== 1 || (err_tick.size() > 0 && (err_tick[0] !== 176 || err_lock[0] !== 0)))
      $display("FAIL skip_err: got n=%0d first=%0d, want 1 at 176 with locked=0",
               err_tick.size(), err_tick.size() > 0 ? err_tick[0] : -1);
    else n_pass++;
    n_checks++;
    if (rise_tick.size() !== 1 || (rise_tick.size() > 0 && rise_tick[0] !== 240))
      $display("FAIL skip_relock: got rises=%0d first=%0d, want 240", rise_tick.size(),
               rise_tick.size() > 0 ? rise_tick[0] : -1);
    else n_pass++;
    n_checks++;
    if (dv_data.size() !== 6) $display("FAIL skip_dv_count: got %0d, want 6", dv_data.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < dv_data.size(); i++) begin
      n_checks++;
      if (dv_data[i] !== exp_d[i] || dv_tick[i] !== exp_t[i])
        $display("FAIL skip_byte[%0d]: got %02h@%0d, want %02h@%0d", i, dv_data[i], dv_tick[i],
                 exp_d[i], exp_t[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset();
    start_stream(8'hFE, 0);
    wait_lock(t);
    n_checks++;
    if (t !== 80) $display("FAIL midrst_lock_tick: got %0d, want 80", t); else n_pass++;
    repeat (20) tick();
    n_checks++;
    if (obs_data !== 8'h03 || obs_locked !== 1'b1)
      $display("FAIL midrst_before: got data=%02h locked=%0b, want 03 1", obs_data, obs_locked);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({data, data_valid, locked, err} !== 11'd0)
      $display("FAIL midrst_async: got %03h, want 000", {data, data_valid, locked, err});
    else n_pass++;
    do_reset();
    start_stream(8'h10, 0);
    wait_lock(t);
    n_checks++;
    if (t !== 80) $display("FAIL midrst_relock_tick: got %0d, want 80", t); else n_pass++;
    collect(16);
    n_checks++;
    if (dv_data.size() !== 1 || err_tick.size() !== 0 ||
        (dv_data.size() > 0 && (dv_data[0] !== 8'h15 || dv_tick[0] !== 96)))
      $display("FAIL midrst_first_byte: got n=%0d err=%0d, want 15@96 and no err",
               dv_data.size(), err_tick.size());
    else n_pass++;
  endtask

`ifdef HEARTBEAT_RX_ERRCNT_EN
  task automatic test_err_count();
    int errs_seen;
    logic v;
    do_reset();
    start_stream(8'h00, 0);
    errs_seen = 0;
    // Each round: 9 valid pairs (PHASE exits after 8) then one invalid pair in HUNT.
    for (int r = 0; r < 320; r++) begin
      for (int s = 0; s < 20; s++) begin
        v = (s < 18) ? s[0] : 1'b0;
        tick_raw(v);
        if (obs_err) errs_seen++;
        if (r == 100 && s == 2) begin
          n_checks++;
          if (err_count !== 8'd100 || errs_seen !== 100)
            $display("FAIL errcnt_mid: got cnt=%0d pulses=%0d, want 100 100", err_count, errs_seen);
          else n_pass++;
        end
      end
    end
    tick_raw(1'b0);
    tick_raw(1'b0);
    n_checks++;
    if (errs_seen !== 320 || err_count !== 8'hFF)
      $display("FAIL errcnt_sat: got cnt=%02h pulses=%0d, want FF 320", err_count, errs_seen);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_aligned();
    test_offset();
    test_wrap();
    test_violation();
    test_seq_skip();
    test_reset_mid();
`ifdef HEARTBEAT_RX_ERRCNT_EN
    test_err_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
